// File: rtl/hsid_band_pack_gen.sv
// hsid_band_pack_gen
// Walks a hyperspectral library and streams pixel/library word pairs
// ("band packs", two bands per word) to the MSE engine. One start request
// produces W = (bands+1)/2 words per vector times library_size vectors,
// issued back-to-back. Both read ports have one cycle of read latency, so each
// beat appears one cycle after its read request.
//
// Optional feature macro: HSID_BAND_PACK_MASK_EN
//   defined   -> for an odd band count, the upper half of the last word of each
//                vector is forced to zero on both band_pack_a and band_pack_b
//   undefined -> memory data is passed through untouched
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   clear                       synchronous abort back to IDLE (beats start)
//   start                       one-cycle scan request, taken only when idle
//   hsp_bands_in                bands per vector, latched on an accepted start
//   hsp_library_size_in         library vector count, latched on accepted start
//   pixel_rd_en/addr/rd_data    pixel buffer read port (word index 0..W-1)
//   lib_rd_en/addr/rd_data      library buffer read port (0..W*size-1)
//   band_pack_a/b               pixel/library word of the current beat
//   band_pack_valid/start/last  beat qualifiers (start = word 0, last = W-1)
//   hsp_ref                     vector index of the current beat
//   hsp_bands                   latched band count
//   idle, done                  status; done is a one-cycle pulse

`ifndef HSID_WORD_WIDTH
`define HSID_WORD_WIDTH 32
`endif
`ifndef HSID_HSP_BANDS_WIDTH
`define HSID_HSP_BANDS_WIDTH 8
`endif
`ifndef HSID_HSP_LIBRARY_WIDTH
`define HSID_HSP_LIBRARY_WIDTH 8
`endif

module hsid_band_pack_gen #(
    parameter int WORD_WIDTH        = `HSID_WORD_WIDTH,
    parameter int HSP_BANDS_WIDTH   = `HSID_HSP_BANDS_WIDTH,
    parameter int HSP_LIBRARY_WIDTH = `HSID_HSP_LIBRARY_WIDTH,
    parameter int ADDR_WIDTH        = HSP_BANDS_WIDTH + HSP_LIBRARY_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         start,
    input  logic [HSP_BANDS_WIDTH-1:0]   hsp_bands_in,
    input  logic [HSP_LIBRARY_WIDTH-1:0] hsp_library_size_in,
    output logic                         pixel_rd_en,
    output logic [HSP_BANDS_WIDTH-1:0]   pixel_addr,
    input  logic [WORD_WIDTH-1:0]        pixel_rd_data,
    output logic                         lib_rd_en,
    output logic [ADDR_WIDTH-1:0]        lib_addr,
    input  logic [WORD_WIDTH-1:0]        lib_rd_data,
    output logic [WORD_WIDTH-1:0]        band_pack_a,
    output logic [WORD_WIDTH-1:0]        band_pack_b,
    output logic                         band_pack_valid,
    output logic                         band_pack_start,
    output logic                         band_pack_last,
    output logic [HSP_LIBRARY_WIDTH-1:0] hsp_ref,
    output logic [HSP_BANDS_WIDTH-1:0]   hsp_bands,
    output logic                         idle,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic                         accept;
    logic                         rd_en;
    logic                         zero_cfg;
    logic                         final_read;
    logic                         word_last;
    logic [HSP_BANDS_WIDTH-1:0]   words_in;
    logic [HSP_BANDS_WIDTH-1:0]   words_last_in;
    logic [HSP_BANDS_WIDTH-1:0]   bands_q;
    logic [HSP_BANDS_WIDTH-1:0]   words_q;
    logic [HSP_BANDS_WIDTH-1:0]   words_last_q;
    logic [HSP_LIBRARY_WIDTH-1:0] size_last_q;
    logic [HSP_BANDS_WIDTH-1:0]   word_idx;
    logic [HSP_LIBRARY_WIDTH-1:0] vec_idx;
    logic [ADDR_WIDTH-1:0]        lib_base;
    logic                         valid_q;
    logic                         start_q;
    logic                         last_q;
    logic [HSP_LIBRARY_WIDTH-1:0] ref_q;
    logic [WORD_WIDTH-1:0]        data_keep;

    // (bands+1)>>1 written as floor(bands/2) + lsb so it never overflows
    assign words_in      = {1'b0, hsp_bands_in[HSP_BANDS_WIDTH-1:1]}
                         + HSP_BANDS_WIDTH'(hsp_bands_in[0]);
    assign words_last_in = words_in - HSP_BANDS_WIDTH'(1);
    assign zero_cfg      = (hsp_bands_in == '0) || (hsp_library_size_in == '0);
    assign word_last     = (word_idx == words_last_q);
    assign final_read    = word_last && (vec_idx == size_last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Clear overrides everything, including a start in the same cycle
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        rd_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = zero_cfg ? DONE : READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                if (final_read) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
            accept  = 1'b0;
        end
    end

    // Library base advances by W per vector, so no multiplier is needed.
    // The beat qualifiers are registered alongside the one-cycle read latency;
    // on clear the read issued this cycle is dropped by clearing valid_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bands_q      <= '0;
            words_q      <= '0;
            words_last_q <= '0;
            size_last_q  <= '0;
            word_idx     <= '0;
            vec_idx      <= '0;
            lib_base     <= '0;
            valid_q      <= 1'b0;
            start_q      <= 1'b0;
            last_q       <= 1'b0;
            ref_q        <= '0;
        end else if (clear) begin
            word_idx <= '0;
            vec_idx  <= '0;
            lib_base <= '0;
            valid_q  <= 1'b0;
            start_q  <= 1'b0;
            last_q   <= 1'b0;
            ref_q    <= '0;
        end else begin
            if (accept) begin
                bands_q      <= hsp_bands_in;
                words_q      <= words_in;
                words_last_q <= words_last_in;
                size_last_q  <= hsp_library_size_in - HSP_LIBRARY_WIDTH'(1);
                word_idx     <= '0;
                vec_idx      <= '0;
                lib_base     <= '0;
            end else if (rd_en) begin
                if (word_last) begin
                    word_idx <= '0;
                    vec_idx  <= vec_idx + HSP_LIBRARY_WIDTH'(1);
                    lib_base <= lib_base + ADDR_WIDTH'(words_q);
                end else begin
                    word_idx <= word_idx + HSP_BANDS_WIDTH'(1);
                end
            end
            valid_q <= rd_en;
            start_q <= rd_en && (word_idx == '0);
            last_q  <= rd_en && word_last;
            if (rd_en) begin
                ref_q <= vec_idx;
            end
        end
    end

`ifdef HSID_BAND_PACK_MASK_EN
    logic mask_q;

    // Marks the last word of a vector with an odd band count, whose upper
    // half holds no real band
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= 1'b0;
        end else if (clear) begin
            mask_q <= 1'b0;
        end else begin
            mask_q <= rd_en && word_last && bands_q[0];
        end
    end

    assign data_keep = {{(WORD_WIDTH - WORD_WIDTH/2){~mask_q}}, {(WORD_WIDTH/2){1'b1}}}
                     & {WORD_WIDTH{valid_q}};
`else
    assign data_keep = {WORD_WIDTH{valid_q}};
`endif

    assign pixel_rd_en     = rd_en;
    assign lib_rd_en       = rd_en;
    assign pixel_addr      = rd_en ? word_idx : '0;
    assign lib_addr        = rd_en ? (lib_base + ADDR_WIDTH'(word_idx)) : '0;
    assign band_pack_a     = pixel_rd_data & data_keep;
    assign band_pack_b     = lib_rd_data & data_keep;
    assign band_pack_valid = valid_q;
    assign band_pack_start = start_q;
    assign band_pack_last  = last_q;
    assign hsp_ref         = ref_q;
    assign hsp_bands       = bands_q;
    assign idle            = (state_q == IDLE);
    assign done            = (state_q == DONE);

endmodule
